// File: rtl/uart_transmitter.sv
// UART transmitter, 8 data bits, 1 stop bit, runtime-selectable baud rate.
// Define UART_TX_PARITY_EN to insert an even-parity bit between bit 7 and the stop bit.
module uart_transmitter #(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baudrate_set,
    input  logic [7:0] TxData,
    input  logic       transmit,
    output logic       TxD,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [19:0] DIV_9600   = 20'(CLK_FREQ / 9600);
    localparam logic [19:0] DIV_19200  = 20'(CLK_FREQ / 19200);
    localparam logic [19:0] DIV_38400  = 20'(CLK_FREQ / 38400);
    localparam logic [19:0] DIV_57600  = 20'(CLK_FREQ / 57600);
    localparam logic [19:0] DIV_115200 = 20'(CLK_FREQ / 115200);
    localparam logic [19:0] DIV_230400 = 20'(CLK_FREQ / 230400);
    localparam logic [19:0] DIV_460800 = 20'(CLK_FREQ / 460800);
    localparam logic [19:0] DIV_921600 = 20'(CLK_FREQ / 921600);

    logic [2:0]  r_state;
    logic [19:0] r_div;
    logic [19:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_data;
    logic        r_txd;
    logic [19:0] w_div_sel;
    logic        w_last;

    always_comb begin
        w_div_sel = DIV_9600;
        case (baudrate_set)
            3'd0: w_div_sel = DIV_9600;
            3'd1: w_div_sel = DIV_19200;
            3'd2: w_div_sel = DIV_38400;
            3'd3: w_div_sel = DIV_57600;
            3'd4: w_div_sel = DIV_115200;
            3'd5: w_div_sel = DIV_230400;
            3'd6: w_div_sel = DIV_460800;
            3'd7: w_div_sel = DIV_921600;
            default: w_div_sel = DIV_9600;
        endcase
    end

    // Bit period counter restarts at every state change, so phase follows acceptance.
    assign w_last = (r_cnt == r_div - 20'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_data  <= '0;
            r_txd   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (transmit) begin
                        r_state <= S_START;
                        r_data  <= TxData;
                        r_div   <= w_div_sel;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_txd   <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= S_DATA;
                        r_txd   <= r_data[0];
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end
                S_DATA: begin
                    if (w_last) begin
                        r_cnt <= '0;
                        if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= S_PARITY;
                            r_txd   <= ^r_data;
`else
                            r_state <= S_STOP;
                            r_txd   <= 1'b1;
`endif
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_txd <= r_data[r_bit + 3'd1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= S_STOP;
                        r_txd   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    assign TxD  = r_txd;
    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_STOP) && w_last;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at 100 MHz; follows UART_TX_PARITY_EN for frame shape.
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] baudrate_set = '0;
    logic [7:0] TxData = '0;
    logic       transmit = 1'b0;
    logic       TxD, busy, done;
    int         checks = 0;
    int         failures = 0;

`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    uart_transmitter #(.CLK_FREQ(100_000_000)) dut (
        .clk(clk), .reset(reset), .baudrate_set(baudrate_set), .TxData(TxData),
        .transmit(transmit), .TxD(TxD), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Expected line levels, one per bit period: start, data LSB first, [parity], stop.
    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        logic [10:0] f;
        f = '0;
        f[8:1] = d;
`ifdef UART_TX_PARITY_EN
        f[9]  = ^d;
        f[10] = 1'b1;
`else
        f[9]  = 1'b1;
`endif
        return f;
    endfunction

    task automatic start_tx(input logic [2:0] b, input logic [7:0] d);
        @(negedge clk);
        baudrate_set = b;
        TxData = d;
        transmit = 1'b1;
        @(posedge clk);
    endtask

    // Samples one frame (k=1 is the cycle after acceptance) plus the cycle after it.
    task automatic capture(input int div, input bit drop_tx, input int mut_k,
                           output logic [10:0] bits, output int instab, output int done_at,
                           output int done_cnt, output int busy_lo,
                           output logic post_txd, output logic post_busy);
        int total, idx;
        total = NBITS * div;
        bits = '0; instab = 0; done_at = 0; done_cnt = 0; busy_lo = 0;
        post_txd = 1'bx; post_busy = 1'bx;
        for (int k = 1; k <= total + 1; k++) begin
            @(negedge clk);
            if (k == 1 && drop_tx) transmit = 1'b0;
            if (k == mut_k) begin
                TxData = 8'hFF; baudrate_set = 3'd0; transmit = 1'b1;
            end
            if (k == mut_k + 1) transmit = 1'b0;
            if (k <= total) begin
                idx = (k - 1) / div;
                if ((k - 1) % div == 0) bits[idx] = TxD;
                else if (TxD !== bits[idx]) instab++;
                if (busy !== 1'b1) busy_lo++;
            end else begin
                post_txd = TxD;
                post_busy = busy;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; transmit = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (TxD !== 1'b1) begin failures++; $display("FAIL reset_txd got %b expected 1", TxD); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b expected 0", done); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got %b expected 0", busy); end
    endtask

    task automatic test_frame(input string nm, input logic [2:0] b, input logic [7:0] d, input int div);
        logic [10:0] bits; int instab, done_at, done_cnt, busy_lo; logic pt, pb;
        start_tx(b, d);
        capture(div, 1'b1, -1, bits, instab, done_at, done_cnt, busy_lo, pt, pb);
        checks++; if (bits !== exp_frame(d)) begin failures++; $display("FAIL %s_bits got %h expected %h", nm, bits, exp_frame(d)); end
        checks++; if (instab != 0) begin failures++; $display("FAIL %s_stable got %0d expected 0", nm, instab); end
        checks++; if (done_at != NBITS * div || done_cnt != 1) begin
            failures++; $display("FAIL %s_done got at=%0d n=%0d expected at=%0d n=1", nm, done_at, done_cnt, NBITS * div);
        end
        checks++; if (busy_lo != 0) begin failures++; $display("FAIL %s_busy got %0d low cycles expected 0", nm, busy_lo); end
        checks++; if (pt !== 1'b1 || pb !== 1'b0) begin
            failures++; $display("FAIL %s_after got txd=%b busy=%b expected txd=1 busy=0", nm, pt, pb);
        end
    endtask

    task automatic test_back_to_back;
        logic [10:0] bits; int instab, done_at, done_cnt, busy_lo; logic pt, pb;
        start_tx(3'd7, 8'h00);
        capture(108, 1'b0, -1, bits, instab, done_at, done_cnt, busy_lo, pt, pb);
        checks++; if (bits !== exp_frame(8'h00) || done_at != NBITS * 108) begin
            failures++; $display("FAIL b2b_first got bits=%h done=%0d expected bits=%h done=%0d", bits, done_at, exp_frame(8'h00), NBITS * 108);
        end
        checks++; if (pt !== 1'b1 || pb !== 1'b0) begin
            failures++; $display("FAIL b2b_gap got txd=%b busy=%b expected txd=1 busy=0", pt, pb);
        end
        capture(108, 1'b1, -1, bits, instab, done_at, done_cnt, busy_lo, pt, pb);
        checks++; if (bits !== exp_frame(8'h00) || busy_lo != 0 || done_at != NBITS * 108) begin
            failures++; $display("FAIL b2b_second got bits=%h busy_lo=%0d done=%0d expected bits=%h busy_lo=0 done=%0d",
                                 bits, busy_lo, done_at, exp_frame(8'h00), NBITS * 108);
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_release got busy=%b expected 0", busy); end
    endtask

    task automatic test_mid_change;
        logic [10:0] bits; int instab, done_at, done_cnt, busy_lo; logic pt, pb;
        start_tx(3'd7, 8'h00);
        capture(108, 1'b1, 4 * 108 + 5, bits, instab, done_at, done_cnt, busy_lo, pt, pb);
        checks++; if (bits !== exp_frame(8'h00) || instab != 0) begin
            failures++; $display("FAIL midchg_bits got %h instab=%0d expected %h instab=0", bits, instab, exp_frame(8'h00));
        end
        checks++; if (done_at != NBITS * 108) begin failures++; $display("FAIL midchg_len got %0d expected %0d", done_at, NBITS * 108); end
        @(negedge clk);
        checks++; if (pt !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL midchg_noqueue got txd=%b busy=%b expected txd=1 busy=0", pt, busy);
        end
    endtask

    task automatic test_reset_mid;
        int done_seen = 0;
        start_tx(3'd7, 8'h00);
        for (int k = 1; k <= 4 * 108 + 50; k++) begin
            @(negedge clk);
            if (k == 1) transmit = 1'b0;
            if (done === 1'b1) done_seen++;
        end
        checks++; if (TxD !== 1'b0) begin failures++; $display("FAIL rstmid_pre got txd=%b expected 0", TxD); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (TxD !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL rstmid_abort got txd=%b busy=%b done=%b expected 1 0 0", TxD, busy, done);
        end
        checks++; if (done_seen != 0) begin failures++; $display("FAIL rstmid_nodone got %0d expected 0", done_seen); end
        reset = 1'b0;
        test_frame("rstmid_clean", 3'd7, 8'h3C, 108);
    endtask

    task automatic test_reset_vs_transmit;
        @(negedge clk);
        reset = 1'b1; transmit = 1'b1; TxData = 8'h00;
        @(negedge clk);
        reset = 1'b0; transmit = 1'b0;
        checks++; if (busy !== 1'b0 || TxD !== 1'b1) begin
            failures++; $display("FAIL rst_wins got busy=%b txd=%b expected busy=0 txd=1", busy, TxD);
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_wins_drop got busy=%b expected 0", busy); end
    endtask

    task automatic test_baud_table;
        int divs [8] = '{10416, 5208, 2604, 1736, 868, 434, 217, 108};
        int low;
        logic nxt;
        for (int i = 0; i < 8; i++) begin
            start_tx(3'(i), 8'h55);
            low = 0; nxt = 1'bx;
            for (int k = 1; k <= divs[i] + 1; k++) begin
                @(negedge clk);
                if (k == 1) transmit = 1'b0;
                if (k <= divs[i] && TxD === 1'b0) low++;
                if (k == divs[i] + 1) nxt = TxD;
            end
            checks++; if (low != divs[i]) begin failures++; $display("FAIL baud%0d_start got %0d expected %0d", i, low, divs[i]); end
            checks++; if (nxt !== 1'b1) begin failures++; $display("FAIL baud%0d_bit0 got %b expected 1", i, nxt); end
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
        end
    endtask

    initial begin
        test_reset;
        test_frame("a5_115200", 3'd4, 8'hA5, 868);
        test_frame("01_921600", 3'd7, 8'h01, 108);
        test_back_to_back;
        test_mid_change;
        test_reset_mid;
        test_reset_vs_transmit;
        test_baud_table;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
